// File: rtl/decoder_scan_n.sv
// Registered N-to-2^N one-hot decoder with enable, direct/scan modes,
// selectable output polarity and a frame-sync wrap pulse.
module decoder_scan_n #(
  parameter int unsigned N          = 2,
  parameter int unsigned DWELL_W    = 4,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic [N-1:0]       a,
  input  logic [DWELL_W-1:0] dwell,
  output logic [(2**N)-1:0]  y,
  output logic [N-1:0]       idx,
  output logic               valid,
  output logic               wrap
);

  localparam int unsigned M = 2**N;
  localparam logic [M-1:0] INACTIVE = {M{ACTIVE_LOW}};
  localparam logic [N-1:0] IDX_LAST = {N{1'b1}};

  logic [M-1:0]       y_q, y_d;
  logic [N-1:0]       idx_q, idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               wrap_q, wrap_d;

  // Selected bit differs from all others; polarity set by ACTIVE_LOW.
  function automatic logic [M-1:0] code(input logic [N-1:0] k);
    logic [M-1:0] onehot;
    onehot    = '0;
    onehot[k] = 1'b1;
    return ACTIVE_LOW ? ~onehot : onehot;
  endfunction

  always_comb begin
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    y_d     = INACTIVE;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    if (en) begin
      valid_d = 1'b1;
      if (!mode) begin
        idx_d = a;
        cnt_d = '0;
      end else if (cnt_q >= dwell) begin
        // >= lets a mid-count dwell decrease release immediately
        idx_d  = idx_q + N'(1);
        cnt_d  = '0;
        wrap_d = (idx_q == IDX_LAST);
      end else begin
        cnt_d = cnt_q + DWELL_W'(1);
      end
      y_d = code(idx_d);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q     <= INACTIVE;
      idx_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      y_q     <= y_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign y     = y_q;
  assign idx   = idx_q;
  assign valid = valid_q;
  assign wrap  = wrap_q;

endmodule
